// File: rtl/fir_pkg.sv
// Shared widths and state encoding for the time-multiplexed FIR sequencer.
package fir_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int NUM_REGS   = 8;
  localparam int COEF_WIDTH = 16;
  localparam int OUT_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_t;

endpackage

// File: rtl/fir_tap_line.sv
// Enable-gated sample delay line; taps_o[0] holds the newest sample.
module fir_tap_line #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 shift_en_i,
  input  logic [DATA_WIDTH-1:0]                din_i,
  output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  taps_o
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] taps_q;

  // Shift register: new sample enters at index 0, oldest falls off the top.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taps_q <= '0;
    end else if (shift_en_i) begin
      taps_q <= {taps_q[NUM_REGS-2:0], din_i};
    end else begin
      taps_q <= taps_q;
    end
  end

  assign taps_o = taps_q;

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR controller stepping one shared multiply-accumulate across all taps per sample.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = fir_pkg::DATA_WIDTH,
  parameter int NUM_REGS   = fir_pkg::NUM_REGS,
  parameter int COEF_WIDTH = fir_pkg::COEF_WIDTH,
  parameter int OUT_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(NUM_REGS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_WIDTH-1:0]       s_data,
  input  logic                        coef_we,
  input  logic [$clog2(NUM_REGS)-1:0] coef_addr,
  input  logic [COEF_WIDTH-1:0]       coef_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [OUT_WIDTH-1:0]        m_data,
  output logic                        busy
);

  localparam int IDXW   = $clog2(NUM_REGS);
  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;

  fir_state_t                          state_q, state_d;
  logic [IDXW-1:0]                     idx_q, idx_d;
  logic [OUT_WIDTH-1:0]                acc_q, acc_d;
  logic [OUT_WIDTH-1:0]                m_data_q, m_data_d;
  logic                                m_valid_q, m_valid_d;
  logic [COEF_WIDTH-1:0]               coef_q [NUM_REGS];
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] taps_s;
  logic                                shift_en_s;
  logic                                coef_wr_s;
  logic signed [DATA_WIDTH-1:0]        tap_sel_s;
  logic signed [COEF_WIDTH-1:0]        coef_sel_s;
  logic signed [PROD_W-1:0]            prod_s;
  logic [OUT_WIDTH-1:0]                prod_ext_s;
  logic [OUT_WIDTH-1:0]                sum_s;

  fir_tap_line #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_tap_line (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (shift_en_s),
    .din_i      (s_data),
    .taps_o     (taps_s)
  );

  assign tap_sel_s  = taps_s[idx_q];
  assign coef_sel_s = coef_q[idx_q];
  assign prod_s     = tap_sel_s * coef_sel_s;
  assign prod_ext_s = {{(OUT_WIDTH-PROD_W){prod_s[PROD_W-1]}}, prod_s};
  assign sum_s      = acc_q + prod_ext_s;

  // Next-state, datapath and handshake decode.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    shift_en_s = 1'b0;
    coef_wr_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (coef_we) begin
          coef_wr_s = 1'b1;
        end else if (s_valid) begin
          shift_en_s = 1'b1;
          idx_d      = '0;
          acc_d      = '0;
          state_d    = MAC;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        acc_d = sum_s;
        idx_d = idx_q + IDXW'(1);
        if (idx_q == IDXW'(NUM_REGS - 1)) begin
          m_data_d  = sum_s;
          m_valid_d = 1'b1;
          state_d   = OUT;
        end else begin
          state_d = MAC;
        end
      end
      OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d   = IDLE;
        m_valid_d = 1'b0;
      end
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
    end
  end

  // Coefficient bank; writes only land while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        coef_q[k] <= '0;
      end
    end else if (coef_wr_s) begin
      coef_q[coef_addr] <= coef_data;
    end else begin
      coef_q <= coef_q;
    end
  end

  assign s_ready = (state_q == IDLE) && !coef_we;
  assign busy    = (state_q != IDLE);
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed scoreboard bench for fir_mac_sequencer.
module tb_fir_mac_sequencer;
  import fir_pkg::*;

  localparam int OW = OUT_WIDTH;
  localparam int NR = NUM_REGS;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [15:0]   s_data = 16'd0;
  logic          coef_we = 1'b0;
  logic [2:0]    coef_addr = 3'd0;
  logic [15:0]   coef_data = 16'd0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [OW-1:0] m_data;
  logic          busy;

  fir_mac_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            errors = 0;
  int            checks = 0;
  longint        mtap  [NR];
  longint        mcoef [NR];
  logic [OW-1:0] exp_q [$];
  logic [OW-1:0] last_exp;
  int            acc_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NR; k++) begin
      mtap[k]  = 0;
      mcoef[k] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_accept(input logic signed [15:0] d);
    longint sum;
    for (int k = NR - 1; k > 0; k--) mtap[k] = mtap[k-1];
    mtap[0] = longint'(d);
    sum = 0;
    for (int k = 0; k < NR; k++) sum += mtap[k] * mcoef[k];
    exp_q.push_back(OW'(sum));
    acc_cyc = cyc;
  endtask

  task automatic wcoef(input logic [2:0] a, input logic signed [15:0] v);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = a; coef_data = v;
    #1 chk("we_blocks_sready", s_ready, 0);
    @(posedge clk);
    #1 coef_we = 1'b0;
    mcoef[a] = longint'(v);
  endtask

  task automatic send(input logic signed [15:0] d);
    logic ok;
    @(negedge clk);
    s_valid = 1'b1; s_data = d; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (s_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("send_timeout", ok, 1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    model_accept(d);
  endtask

  task automatic wait_valid(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("valid_timeout", ok, 1);
    chk("latency", cyc - acc_cyc, NR);
    chk("sb_nonempty", exp_q.size() > 0, 1);
    last_exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    chk(tag, m_data, last_exp);
  endtask

  task automatic finish_out();
    @(posedge clk);
    @(negedge clk);
    chk("out_done", m_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_mdata", m_data, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    #1 chk("rst_sready", s_ready, 1);

    // impulse response walks out the coefficients
    for (int k = 0; k < NR; k++) wcoef(3'(k), 16'(k + 1));
    for (int i = 0; i < 9; i++) begin
      send((i == 0) ? 16'sd1 : 16'sd0);
      wait_valid("impulse_sb");
      chk("impulse_val", m_data, (i < 8) ? 64'(i + 1) : 64'd0);
      finish_out();
    end

    // signed extremes
    for (int k = 0; k < NR; k++) wcoef(3'(k), -16'sd32768);
    for (int i = 0; i < NR; i++) begin
      send(-16'sd32768);
      wait_valid("sx_sb");
      finish_out();
    end
    chk("sx_max", {29'd0, last_exp}, 64'h0000_0002_0000_0000);
    wcoef(3'd0, -16'sd3);
    for (int k = 1; k < NR; k++) wcoef(3'(k), 16'sd0);
    send(16'sd5);
    wait_valid("sx_neg_sb");
    chk("sx_neg", m_data, 64'h0000_0007_FFFF_FFF1);
    finish_out();

    // backpressure in OUT
    @(negedge clk);
    m_ready = 1'b0;
    send(16'sd7);
    wait_valid("bp_sb");
    s_valid = 1'b1; s_data = 16'sd99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_stable", m_data, last_exp);
      chk("bp_sready", s_ready, 0);
      chk("bp_mvalid", m_valid, 1);
    end
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_sready", s_ready, 1);
    chk("bp_idle_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    model_accept(16'sd99);
    s_valid = 1'b0;
    chk("bp_accept_busy", busy, 1);
    wait_valid("bp_next_sb");
    finish_out();

    // coefficient write during MAC is dropped
    send(16'sd4);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'd100;
    @(posedge clk);
    #1 coef_we = 1'b0;
    wait_valid("drop_a_sb");
    finish_out();
    send(16'sd2);
    wait_valid("drop_b_sb");
    finish_out();

    // write and sample together in IDLE: write first, sample next cycle
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 3'd1; coef_data = 16'sd10;
    s_valid = 1'b1; s_data = 16'sd3;
    #1 chk("prio_sready_low", s_ready, 0);
    @(posedge clk);
    @(negedge clk);
    coef_we = 1'b0;
    mcoef[1] = 10;
    chk("prio_not_accepted", busy, 0);
    #1 chk("prio_sready_high", s_ready, 1);
    @(posedge clk);
    @(negedge clk);
    model_accept(16'sd3);
    s_valid = 1'b0;
    wait_valid("prio_sb");
    chk("prio_val", m_data, 64'd11);
    finish_out();

    // reset in the middle of MAC
    send(16'sd6);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_mvalid", m_valid, 0);
    chk("midrst_mdata", m_data, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    send(16'sd9);
    wait_valid("postrst_sb");
    chk("postrst_zero", m_data, 0);
    finish_out();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Time-multiplexed FIR controller for the FIR accelerator. It accepts one raw sensor sample per valid/ready handshake and shifts it into an enable-gated tap line. It then steps a single shared multiplier-accumulator across all NUM_REGS taps against a programmable coefficient bank, and presents the filtered result on an output valid/ready port. It sits between the sensor sample source and the downstream consumer, replacing a free-running shift register plus NUM_REGS parallel multipliers.

## Interface
- DATA_WIDTH, 16: sample width, signed two's complement.
- NUM_REGS, 8: tap count, ≥2.
- COEF_WIDTH, 16: coefficient width, signed.
- OUT_WIDTH, DATA_WIDTH+COEF_WIDTH+$clog2(NUM_REGS): accumulator and result width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- s_valid  in  1  sample offered.
- s_ready  out  1  block accepts sample this cycle.
- s_data  in  DATA_WIDTH  sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(NUM_REGS)  coefficient index.
- coef_data  in  COEF_WIDTH  coefficient value.
- m_valid  out  1  result valid.
- m_ready  in  1  consumer accepts result.
- m_data  out  OUT_WIDTH  filter result.
- busy  out  1  state ≠ IDLE.

## Operation
- Filter: y = Σ tap[k]·coef[k], k = 0..NUM_REGS-1. tap[0] is the newest sample.
- FSM states: IDLE, MAC, OUT.
- IDLE: s_ready = !coef_we.
  - If coef_we is high: write coef[coef_addr] and stay in IDLE. The write has priority over the sample, so an offered sample waits.
  - Else if s_valid is high: the sample is accepted. The tap line shifts (tap[k] ← tap[k-1], tap[0] ← s_data), idx ← 0, acc ← 0, next state MAC.
- MAC: acc ← acc + tap[idx]·coef[idx], idx ← idx+1.
  - After the step with idx = NUM_REGS-1: m_data ← final sum, next state OUT.
  - coef_we is ignored and the write is dropped. s_ready = 0.
- OUT: m_valid = 1. m_data holds stable until m_ready is sampled high, then next state IDLE. coef_we is ignored.
- Arithmetic:
  - Full-precision signed products, sign-extended to OUT_WIDTH.
  - No saturation and no rounding. Overflow cannot occur at the stated OUT_WIDTH.
- Reset values: state IDLE, taps 0, coefs 0, acc 0, idx 0, m_data 0, m_valid 0, busy 0. s_ready = 1 once rst deasserts.
- Reset mid-operation (any state): immediate asynchronous return to reset values. Any in-flight result is lost.

## Timing
- Acceptance edge E0: s_valid & s_ready are high at a rising edge in IDLE.
- MAC occupies the NUM_REGS cycles following E0.
- m_valid rises at edge E0+NUM_REGS and is registered.
- Minimum sample period: NUM_REGS+2 cycles (IDLE 1, MAC NUM_REGS, OUT 1 with m_ready already high).
- s_ready is low from E0 until the cycle after the OUT handshake.
- Coefficient write takes effect at the edge where it is sampled. It is visible to the next accepted sample.
- All outputs are registered except:
  - s_ready: a combinational decode of the state register and coef_we.
  - busy: a decode of the state register.
- No combinational path from m_ready to any output.

## Structure
- Package fir_pkg holds:
  - default widths DATA_WIDTH, NUM_REGS, COEF_WIDTH;
  - the derived OUT_WIDTH;
  - typedef enum fir_state_t {IDLE, MAC, OUT}.
- Sub-module fir_tap_line: NUM_REGS × DATA_WIDTH shift register with shift_en, asynchronous active-low reset, and parallel tap outputs. It shifts only when shift_en is high.
- The top level holds:
  - the FSM;
  - the idx counter;
  - the coefficient bank;
  - the idx-selected tap/coef muxes;
  - one multiplier;
  - the accumulator.

## Test plan
- Reset: assert rst low mid-sim → m_valid=0, m_data=0, busy=0. After release, s_ready=1.
- Impulse: coef[k]=k+1, feed 1 then seven 0s, m_ready tied high → results 1,2,3,4,5,6,7,8. A ninth 0 → result 0. Each m_valid is exactly NUM_REGS cycles after its acceptance edge.
- Signed extremes:
  - all coefs = -32768, feed eight samples of -32768 → final m_data = 8·2^30 = 2^33, positive, no wrap;
  - coef[0]=-3, others 0, sample 5 → m_data = -15, sign-extended.
- Backpressure: hold m_ready low for 5 cycles in OUT with s_valid high → m_data stable, s_ready=0, no sample accepted. When m_ready goes high, the next sample is accepted one cycle later.
- Coefficient priority:
  - coef_we during MAC (coef[0]←100) → dropped, result unchanged;
  - coef_we and s_valid together in IDLE → write applied, sample accepted on the following cycle.
- Reset mid-MAC: pull rst low at E0+3 → busy=0 and m_valid=0 immediately. The next sample after release sees all-zero taps and coefs, giving result 0.
